// File: rtl/wb_port_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | wb_port_arbiter_if                                                 |
// | Writeback-port bundle: pipeline/long-latency inputs, RF write out. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface wb_port_arbiter_if;
  logic        pipe_we;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_data;
  logic        lu_valid;
  logic [4:0]  lu_addr;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        stall_req;
  logic        lu_pending;

  modport slave (
    input  pipe_we, pipe_addr, pipe_data, lu_valid, lu_addr, lu_data,
    output lu_ready, rf_we, rf_addr, rf_data, stall_req, lu_pending
  );

  modport master (
    output pipe_we, pipe_addr, pipe_data, lu_valid, lu_addr, lu_data,
    input  lu_ready, rf_we, rf_addr, rf_data, stall_req, lu_pending
  );
endinterface
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | wb_port_arbiter                                                    |
// | Shares one RF write port between the pipeline and a 2-deep queue.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module wb_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  wb_port_arbiter_if.slave bus
);

  localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);
  localparam logic [3:0] c_starve_max   = 4'd15;

  logic [4:0]  r_q_addr [2];
  logic [31:0] r_q_data [2];
  logic [1:0]  r_q_kill;
  logic [1:0]  r_count;
  logic [3:0]  r_starve;
  logic        r_stall;
  logic        r_rf_we;
  logic [4:0]  r_rf_addr;
  logic [31:0] r_rf_data;

  logic [1:0]  w_valid;
  logic        w_pipe_busy;
  logic        w_head_live;
  logic        w_grant;
  logic        w_pop;
  logic        w_lu_ready;
  logic        w_accept;
  logic        w_lu_nz;
  logic        w_bypass;
  logic        w_enq;
  logic        w_enq_kill;
  logic [1:0]  w_cnt_ap;
  logic [1:0]  w_sq_kill;
  logic [4:0]  w_n_addr [2];
  logic [31:0] w_n_data [2];
  logic [1:0]  w_n_kill;
  logic [1:0]  w_n_count;
  logic [3:0]  w_starve_next;

  assign w_valid[0]  = (r_count != 2'd0);
  assign w_valid[1]  = (r_count == 2'd2);
  assign w_pipe_busy = bus.pipe_we & (bus.pipe_addr != 5'd0);
  assign w_head_live = w_valid[0] & ~r_q_kill[0];
  assign w_grant     = w_head_live & ~w_pipe_busy;
  assign w_pop       = w_valid[0] & (r_q_kill[0] | w_grant);
  assign w_lu_ready  = ~w_valid[1] | w_pop;
  assign w_accept    = bus.lu_valid & w_lu_ready;
  assign w_lu_nz     = (bus.lu_addr != 5'd0);
  // An empty queue with a free port lets a new result go straight to the RF.
  assign w_bypass    = w_accept & w_lu_nz & ~w_valid[0] & ~w_pipe_busy;
  assign w_enq       = w_accept & w_lu_nz & ~w_bypass;
  assign w_enq_kill  = w_pipe_busy & (bus.lu_addr == bus.pipe_addr);
  assign w_cnt_ap    = r_count - {1'b0, w_pop};
  assign w_n_count   = w_cnt_ap + {1'b0, w_enq};

  always_comb begin
    w_sq_kill = r_q_kill;
    for (int i = 0; i < 2; i++) begin
      if (w_pipe_busy && w_valid[i] && (r_q_addr[i] == bus.pipe_addr)) begin
        w_sq_kill[i] = 1'b1;
      end
    end
    w_n_addr[0] = r_q_addr[0];
    w_n_addr[1] = r_q_addr[1];
    w_n_data[0] = r_q_data[0];
    w_n_data[1] = r_q_data[1];
    w_n_kill    = w_sq_kill;
    if (w_pop) begin
      w_n_addr[0] = r_q_addr[1];
      w_n_data[0] = r_q_data[1];
      w_n_kill    = {1'b0, w_sq_kill[1]};
    end
    if (w_enq) begin
      if (w_cnt_ap == 2'd0) begin
        w_n_addr[0] = bus.lu_addr;
        w_n_data[0] = bus.lu_data;
        w_n_kill[0] = w_enq_kill;
      end else begin
        w_n_addr[1] = bus.lu_addr;
        w_n_data[1] = bus.lu_data;
        w_n_kill[1] = w_enq_kill;
      end
    end
  end

  always_comb begin
    w_starve_next = r_starve;
    if (!w_valid[0] || w_pop) begin
      w_starve_next = 4'd0;
    end else if (w_head_live && (r_starve != c_starve_max)) begin
      w_starve_next = r_starve + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_addr[0] <= '0;
      r_q_addr[1] <= '0;
      r_q_data[0] <= '0;
      r_q_data[1] <= '0;
      r_q_kill    <= '0;
      r_count     <= '0;
      r_starve    <= '0;
      r_stall     <= 1'b0;
      r_rf_we     <= 1'b0;
      r_rf_addr   <= '0;
      r_rf_data   <= '0;
    end else begin
      r_q_addr[0] <= w_n_addr[0];
      r_q_addr[1] <= w_n_addr[1];
      r_q_data[0] <= w_n_data[0];
      r_q_data[1] <= w_n_data[1];
      r_q_kill    <= w_n_kill;
      r_count     <= w_n_count;
      r_starve    <= w_starve_next;
      r_stall     <= (w_starve_next >= c_starve_limit);
      if (w_pipe_busy) begin
        r_rf_we   <= 1'b1;
        r_rf_addr <= bus.pipe_addr;
        r_rf_data <= bus.pipe_data;
      end else if (w_grant) begin
        r_rf_we   <= 1'b1;
        r_rf_addr <= r_q_addr[0];
        r_rf_data <= r_q_data[0];
      end else if (w_bypass) begin
        r_rf_we   <= 1'b1;
        r_rf_addr <= bus.lu_addr;
        r_rf_data <= bus.lu_data;
      end else begin
        r_rf_we   <= 1'b0;
      end
    end
  end

  assign bus.lu_ready   = w_lu_ready;
  assign bus.lu_pending = (w_valid[0] & ~r_q_kill[0]) | (w_valid[1] & ~r_q_kill[1]);
  assign bus.rf_we      = r_rf_we;
  assign bus.rf_addr    = r_rf_addr;
  assign bus.rf_data    = r_rf_data;
  assign bus.stall_req  = r_stall;

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// tb_wb_port_arbiter: directed vector table, multi-cycle sequences, and a
// queue-based reference model under random traffic.
module tb_wb_port_arbiter;

  localparam int LIMIT = 4;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  bit   model_en = 1'b0;

  wb_port_arbiter_if bus();

  wb_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
    @(posedge clk);
    #1;
    bus.pipe_we = pwe; bus.pipe_addr = pa; bus.pipe_data = pd;
    bus.lu_valid = lv; bus.lu_addr = la; bus.lu_data = ld;
  endtask

  // Reference model: an ordered list of pending results plus expected RF regs.
  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    bit          kill;
  } ent_t;

  ent_t        mq[$];
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        m_stall;
  int          m_starve;

  task automatic model_step();
    bit busy, pop, rdy, pend, hl, wr, was_empty;
    logic [4:0]  wa;
    logic [31:0] wd;
    ent_t e;
    if (!rst_n) begin
      mq.delete();
      m_we = 1'b0; m_addr = '0; m_data = '0; m_stall = 1'b0; m_starve = 0;
    end
    busy = bus.pipe_we && (bus.pipe_addr != 0);
    hl   = (mq.size() > 0) && !mq[0].kill;
    pop  = (mq.size() > 0) && (mq[0].kill || !busy);
    rdy  = (mq.size() < 2) || pop;
    pend = 1'b0;
    foreach (mq[i]) if (!mq[i].kill) pend = 1'b1;
    chk("rand_lu_ready",   32'(bus.lu_ready),   32'(rdy));
    chk("rand_lu_pending", 32'(bus.lu_pending), 32'(pend));
    chk("rand_rf_we",      32'(bus.rf_we),      32'(m_we));
    chk("rand_rf_addr",    32'(bus.rf_addr),    32'(m_addr));
    chk("rand_rf_data",    bus.rf_data,         m_data);
    chk("rand_stall_req",  32'(bus.stall_req),  32'(m_stall));
    if (!rst_n) return;
    was_empty = (mq.size() == 0);
    wr = 1'b0; wa = '0; wd = '0;
    if (busy) begin
      wr = 1'b1; wa = bus.pipe_addr; wd = bus.pipe_data;
    end else if (hl) begin
      wr = 1'b1; wa = mq[0].addr; wd = mq[0].data;
    end else if (was_empty && bus.lu_valid && rdy && bus.lu_addr != 0) begin
      wr = 1'b1; wa = bus.lu_addr; wd = bus.lu_data;
    end
    if (busy) foreach (mq[i]) if (mq[i].addr == bus.pipe_addr) mq[i].kill = 1'b1;
    if (was_empty || pop) m_starve = 0;
    else if (hl) m_starve = (m_starve < 15) ? m_starve + 1 : 15;
    if (pop) void'(mq.pop_front());
    if (bus.lu_valid && rdy && bus.lu_addr != 0 && !(was_empty && !busy)) begin
      e.addr = bus.lu_addr; e.data = bus.lu_data;
      e.kill = busy && (bus.lu_addr == bus.pipe_addr);
      mq.push_back(e);
    end
    m_stall = (m_starve >= LIMIT);
    m_we = wr;
    if (wr) begin
      m_addr = wa; m_data = wd;
    end
  endtask

  always @(negedge clk) if (model_en) model_step();

  typedef struct {
    logic        pwe;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic        lv;
    logic [4:0]  la;
    logic [31:0] ld;
    logic        e_ready;
    logic        e_pend;
    logic        e_we;
    logic [4:0]  e_a;
    logic [31:0] e_d;
    logic        e_stall;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 1'b0, 5'd0, 32'h0,    1'b0};
    vecs[1]  = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd5, 32'h1234, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,    1'b0};
    vecs[2]  = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 1'b1, 5'd5, 32'h1234, 1'b0};
    vecs[3]  = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd0, 32'hDEAD, 1'b1, 1'b0, 1'b0, 5'd5, 32'h1234, 1'b0};
    vecs[4]  = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 1'b0, 5'd5, 32'h1234, 1'b0};
    vecs[5]  = '{1'b1, 5'd6, 32'h66, 1'b1, 5'd6, 32'h77,   1'b1, 1'b0, 1'b0, 5'd5, 32'h1234, 1'b0};
    vecs[6]  = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 1'b1, 5'd6, 32'h66,   1'b0};
    vecs[7]  = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 1'b0, 5'd6, 32'h66,   1'b0};
    vecs[8]  = '{1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'h70,   1'b1, 1'b0, 1'b0, 5'd6, 32'h66,   1'b0};
    vecs[9]  = '{1'b1, 5'd7, 32'hAA, 1'b0, 5'd0, 32'h0,    1'b1, 1'b1, 1'b1, 5'd3, 32'h33,   1'b0};
    vecs[10] = '{1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 1'b1, 5'd7, 32'hAA,   1'b0};
    vecs[11] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 1'b0, 5'd7, 32'hAA,   1'b0};

    rst_n = 1'b0;
    bus.pipe_we = 1'b0; bus.pipe_addr = '0; bus.pipe_data = '0;
    bus.lu_valid = 1'b0; bus.lu_addr = '0; bus.lu_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].pwe, vecs[i].pa, vecs[i].pd, vecs[i].lv, vecs[i].la, vecs[i].ld);
      @(negedge clk);
      chk($sformatf("vec%0d_lu_ready", i),   32'(bus.lu_ready),   32'(vecs[i].e_ready));
      chk($sformatf("vec%0d_lu_pending", i), 32'(bus.lu_pending), 32'(vecs[i].e_pend));
      chk($sformatf("vec%0d_rf_we", i),      32'(bus.rf_we),      32'(vecs[i].e_we));
      chk($sformatf("vec%0d_rf_addr", i),    32'(bus.rf_addr),    32'(vecs[i].e_a));
      chk($sformatf("vec%0d_rf_data", i),    bus.rf_data,         vecs[i].e_d);
      chk($sformatf("vec%0d_stall_req", i),  32'(bus.stall_req),  32'(vecs[i].e_stall));
    end

    // Pipeline hogs the port: queue fills, head starves, then drains in order.
    drive(1'b1, 5'd3, 32'h301, 1'b1, 5'd8, 32'h800);
    @(negedge clk); chk("starve_offer1_ready", 32'(bus.lu_ready), 32'd1);
    drive(1'b1, 5'd3, 32'h302, 1'b1, 5'd9, 32'h900);
    @(negedge clk); chk("starve_offer2_ready", 32'(bus.lu_ready), 32'd1);
    chk("starve_pending", 32'(bus.lu_pending), 32'd1);
    drive(1'b1, 5'd3, 32'h303, 1'b1, 5'd10, 32'hA00);
    @(negedge clk); chk("starve_offer3_ready", 32'(bus.lu_ready), 32'd0);
    chk("starve_c2_stall", 32'(bus.stall_req), 32'd0);
    drive(1'b1, 5'd3, 32'h304, 1'b0, 5'd0, 32'h0);
    @(negedge clk); chk("starve_c3_stall", 32'(bus.stall_req), 32'd0);
    drive(1'b1, 5'd3, 32'h305, 1'b0, 5'd0, 32'h0);
    @(negedge clk); chk("starve_c4_stall", 32'(bus.stall_req), 32'd0);
    drive(1'b1, 5'd3, 32'h306, 1'b0, 5'd0, 32'h0);
    @(negedge clk); chk("starve_c5_stall", 32'(bus.stall_req), 32'd1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk); chk("starve_c6_stall", 32'(bus.stall_req), 32'd1);
    chk("starve_c6_ready_on_pop", 32'(bus.lu_ready), 32'd1);
    chk("starve_c6_rf_addr", 32'(bus.rf_addr), 32'd3);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk); chk("starve_c7_stall", 32'(bus.stall_req), 32'd0);
    chk("drain_first_we", 32'(bus.rf_we), 32'd1);
    chk("drain_first_addr", 32'(bus.rf_addr), 32'd8);
    chk("drain_first_data", bus.rf_data, 32'h800);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk); chk("drain_second_we", 32'(bus.rf_we), 32'd1);
    chk("drain_second_addr", 32'(bus.rf_addr), 32'd9);
    chk("drain_second_data", bus.rf_data, 32'h900);
    chk("drain_pending", 32'(bus.lu_pending), 32'd0);

    // Full queue, asynchronous reset mid-cycle.
    drive(1'b1, 5'd3, 32'h311, 1'b1, 5'd11, 32'hB00);
    drive(1'b1, 5'd3, 32'h312, 1'b1, 5'd12, 32'hC00);
    drive(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'h0);
    chk("prerst_rf_we", 32'(bus.rf_we), 32'd1);
    chk("prerst_pending", 32'(bus.lu_pending), 32'd1);
    chk("prerst_ready_full", 32'(bus.lu_ready), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
    chk("rst_rf_addr", 32'(bus.rf_addr), 32'd0);
    chk("rst_rf_data", bus.rf_data, 32'd0);
    chk("rst_stall", 32'(bus.stall_req), 32'd0);
    chk("rst_pending", 32'(bus.lu_pending), 32'd0);
    chk("rst_ready", 32'(bus.lu_ready), 32'd1);
    bus.pipe_we = 1'b0; bus.pipe_addr = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("postrst%0d_rf_we", k), 32'(bus.rf_we), 32'd0);
      chk($sformatf("postrst%0d_pending", k), 32'(bus.lu_pending), 32'd0);
    end

    // Random traffic against the reference model; small address range forces collisions.
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_en = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      rst_n         = ($urandom_range(0, 199) != 0);
      bus.pipe_we   = 1'($urandom_range(0, 1));
      bus.pipe_addr = 5'($urandom_range(0, 3));
      bus.pipe_data = $urandom;
      bus.lu_valid  = ($urandom_range(0, 2) != 0);
      bus.lu_addr   = 5'($urandom_range(0, 3));
      bus.lu_data   = $urandom;
    end
    @(posedge clk);
    #1;
    model_en = 1'b0;
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
